// File: rtl/snoop_pkg.sv
// Shared snoop-bus definitions: bus-op encodings, arbiter state encoding
// and the default memory latency.
package snoop_pkg;

    localparam int MEM_LAT_DEF = 2;

    typedef enum logic [1:0] {
        OP_BUSRD   = 2'b00,
        OP_BUSRDX  = 2'b01,
        OP_BUSUPGR = 2'b10,
        OP_RSVD    = 2'b11
    } bus_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SNOOP = 3'd2,
        ST_MEM   = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } arb_state_e;

    // (idx + 1) mod 3 for a 2-bit core index
    function automatic logic [1:0] next_core(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: first set request at or after ptr wins.
module rr_pick3
    import snoop_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic [1:0] idx
);

    logic [1:0] c0, c1, c2;

    assign c0 = (ptr >= 2'd3) ? 2'd0 : ptr;
    assign c1 = next_core(c0);
    assign c2 = next_core(c1);

    // priority scan in rotated order starting at ptr
    always_comb begin
        gnt = 3'b000;
        idx = 2'd0;
        if (req[c0]) begin
            gnt = 3'b001 << c0;
            idx = c0;
        end else if (req[c1]) begin
            gnt = 3'b001 << c1;
            idx = c1;
        end else if (req[c2]) begin
            gnt = 3'b001 << c2;
            idx = c2;
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping bus arbiter for three cores: round-robin grant, one broadcast
// cycle, one snoop cycle, then memory read, cache-to-cache flush or direct
// completion, and a one-cycle Done pulse back to the requester.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | bus free; pick a winner when any Req is set
// ST_GRANT | broadcast cycle, BusValid high
// ST_SNOOP | sample SnoopHit (requester bit masked off), choose path
// ST_MEM   | memory read, MEM_LAT cycles, MemRead on the first only
// ST_FLUSH | owner supplies the line: MemWrite + AbortMem
// ST_DONE  | Done pulse to requester, grant released, ptr advanced
module snoop_bus_arbiter
    import snoop_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] Req,
    input  logic [5:0] ReqOp,
    input  logic [5:0] ReqAddr,
    input  logic [2:0] SnoopHit,
    output logic [2:0] Gnt,
    output logic       BusValid,
    output logic [1:0] BusOp,
    output logic [1:0] BusAddr,
    output logic [1:0] BusSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       AbortMem,
    output logic [2:0] Done,
    output logic       Err
);

    localparam logic [2:0] MEM_LAT_C = 3'(MEM_LAT);

    arb_state_e state, state_nxt;
    logic [1:0] ptr;
    logic [2:0] mem_cnt;
    logic [2:0] pick_gnt;
    logic [1:0] pick_idx;
    logic [2:0] hit_masked;
    logic       multi_hit;

    rr_pick3 u_pick (
        .req (Req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Gnt is the requester's one-hot, so it masks the requester's own hit
    assign hit_masked = SnoopHit & ~Gnt;
    assign multi_hit  = (hit_masked & (hit_masked - 3'd1)) != 3'd0;

    // state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|Req) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = ST_SNOOP;
            ST_SNOOP: begin
                if (BusOp == OP_BUSUPGR || BusOp == OP_RSVD) state_nxt = ST_DONE;
                else if (|hit_masked)                        state_nxt = ST_FLUSH;
                else                                         state_nxt = ST_MEM;
            end
            ST_MEM:   if (mem_cnt == 3'd1) state_nxt = ST_DONE;
            ST_FLUSH: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // transaction latch, grant, round-robin pointer, latency timer, error flag
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Gnt     <= 3'b000;
            BusOp   <= 2'b00;
            BusAddr <= 2'b00;
            BusSrc  <= 2'd0;
            ptr     <= 2'd0;
            mem_cnt <= 3'd0;
            Err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|Req) begin
                        Gnt     <= pick_gnt;
                        BusSrc  <= pick_idx;
                        BusOp   <= ReqOp[{pick_idx, 1'b0} +: 2];
                        BusAddr <= ReqAddr[{pick_idx, 1'b0} +: 2];
                    end
                end
                ST_SNOOP: begin
                    mem_cnt <= MEM_LAT_C;
                    if (BusOp == OP_RSVD || multi_hit) Err <= 1'b1;
                end
                ST_MEM:  mem_cnt <= mem_cnt - 3'd1;
                ST_DONE: begin
                    Gnt <= 3'b000;
                    ptr <= next_core(BusSrc);
                end
                default: ;
            endcase
        end
    end

    // strobes decoded from state and the latency timer only
    always_comb begin
        BusValid = (state == ST_GRANT);
        MemRead  = (state == ST_MEM) && (mem_cnt == MEM_LAT_C);
        MemWrite = (state == ST_FLUSH);
        AbortMem = (state == ST_FLUSH);
        Done     = (state == ST_DONE) ? (3'b001 << BusSrc) : 3'b000;
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random
// traffic with occasional resets.
module tb_snoop_bus_arbiter;

    localparam int MEM_LAT = 2;

    logic       Clock;
    logic       Reset;
    logic [2:0] Req;
    logic [5:0] ReqOp;
    logic [5:0] ReqAddr;
    logic [2:0] SnoopHit;
    logic [2:0] Gnt;
    logic       BusValid;
    logic [1:0] BusOp;
    logic [1:0] BusAddr;
    logic [1:0] BusSrc;
    logic       MemRead;
    logic       MemWrite;
    logic       AbortMem;
    logic [2:0] Done;
    logic       Err;

    int checks = 0;
    int errors = 0;

    snoop_bus_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Req      (Req),
        .ReqOp    (ReqOp),
        .ReqAddr  (ReqAddr),
        .SnoopHit (SnoopHit),
        .Gnt      (Gnt),
        .BusValid (BusValid),
        .BusOp    (BusOp),
        .BusAddr  (BusAddr),
        .BusSrc   (BusSrc),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .AbortMem (AbortMem),
        .Done     (Done),
        .Err      (Err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // ---------------- reference model (transaction level) ----------------
    // m_t counts cycles since the grant (1 = broadcast cycle); m_len is the
    // cycle index of the Done pulse, known once the snoop result is seen.
    localparam int P_NONE = 0, P_MEM = 1, P_FLUSH = 2, P_DIRECT = 3;

    logic       m_busy;
    int         m_src, m_t, m_len, m_path, m_ptr;
    logic [1:0] m_op, m_addr;
    logic       m_err;

    task automatic model_reset();
        m_busy = 1'b0; m_src = 0; m_t = 0; m_len = 0; m_path = P_NONE;
        m_ptr = 0; m_op = 2'b00; m_addr = 2'b00; m_err = 1'b0;
    endtask

    // advance the model by one rising edge using the currently driven inputs
    task automatic model_step();
        logic [2:0] hits;
        int nh;
        int w;
        logic found;
        if (!m_busy) begin
            found = 1'b0;
            w = 0;
            for (int k = 0; k < 3; k++) begin
                if (!found && Req[(m_ptr + k) % 3]) begin
                    found = 1'b1;
                    w = (m_ptr + k) % 3;
                end
            end
            if (found) begin
                m_busy = 1'b1; m_src = w; m_t = 1; m_len = 0; m_path = P_NONE;
                m_op   = ReqOp[2*w +: 2];
                m_addr = ReqAddr[2*w +: 2];
            end
        end else if (m_t == m_len) begin
            m_busy = 1'b0;
            m_ptr  = (m_src + 1) % 3;
        end else begin
            if (m_t == 2) begin
                hits = SnoopHit & ~(3'(1) << m_src);
                nh = $countones(hits);
                if (m_op == 2'b11 || nh > 1) m_err = 1'b1;
                if (m_op == 2'b10 || m_op == 2'b11) begin m_path = P_DIRECT; m_len = 3; end
                else if (nh > 0)                      begin m_path = P_FLUSH;  m_len = 4; end
                else                                  begin m_path = P_MEM;    m_len = 3 + MEM_LAT; end
            end
            m_t++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [2:0] e_gnt;
        e_gnt = m_busy ? (3'(1) << m_src) : 3'b000;
        check("gnt",      32'(Gnt),      32'(e_gnt));
        check("busvalid", 32'(BusValid), 32'(m_busy && m_t == 1));
        check("busop",    32'(BusOp),    32'(m_op));
        check("busaddr",  32'(BusAddr),  32'(m_addr));
        check("bussrc",   32'(BusSrc),   32'(m_src));
        check("memread",  32'(MemRead),  32'(m_busy && m_path == P_MEM   && m_t == 3));
        check("memwrite", 32'(MemWrite), 32'(m_busy && m_path == P_FLUSH && m_t == 3));
        check("abortmem", 32'(AbortMem), 32'(m_busy && m_path == P_FLUSH && m_t == 3));
        check("done",     32'(Done),     32'((m_busy && m_t == m_len) ? e_gnt : 3'b000));
        check("err",      32'(Err),      32'(m_err));
    endtask

    // one compare process: outputs settle after each rising edge
    always @(posedge Clock) begin
        #1;
        compare_model();
    end

    // drive inputs for the current cycle, advance the model, go to next cycle
    task automatic step(input logic [2:0] r, input logic [5:0] op,
                        input logic [5:0] ad, input logic [2:0] h);
        Req = r; ReqOp = op; ReqAddr = ad; SnoopHit = h;
        model_step();
        @(negedge Clock);
    endtask

    // asynchronous reset asserted mid-cycle, held for one edge
    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        #1;
        check("rst_outputs_zero",
              32'({Gnt, BusValid, BusOp, BusAddr, BusSrc, MemRead, MemWrite, AbortMem, Done, Err}),
              32'd0);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 12) begin
            step(3'b000, 6'd0, 6'd0, 3'b000);
            n++;
        end
        check("drain_idle", 32'(m_busy), 32'd0);
    endtask

    function automatic logic [2:0] rand_hit();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6)      return 3'b000;
        else if (sel < 9) return 3'(1) << $urandom_range(0, 2);
        else              return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic [5:0] rand_ops();
        logic [5:0] v;
        for (int i = 0; i < 3; i++)
            v[2*i +: 2] = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        return v;
    endfunction

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    logic [2:0] g_seq [4];
    logic [2:0] d_seq [4];

    initial begin
        int ng, nd;
        Reset = 1'b1; Req = '0; ReqOp = '0; ReqAddr = '0; SnoopHit = '0;
        model_reset();
        @(negedge Clock);
        check("reset_gnt", 32'(Gnt), 32'd0);
        check("reset_err", 32'(Err), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        // core 0 BusRd to address 2, no hits: MEM path
        step(3'b001, 6'b000000, 6'b000010, 3'b000);
        check("s1_gnt_c1", 32'(Gnt), 32'b001);
        check("s1_busaddr", 32'(BusAddr), 32'd2);
        check("s1_busvalid_c1", 32'(BusValid), 32'd1);
        step(3'b000, 6'b111111, 6'b111111, 3'b000);
        check("s1_busaddr_held", 32'(BusAddr), 32'd2);
        step(3'b000, 6'd0, 6'd0, 3'b000);
        check("s1_memread_c3", 32'(MemRead), 32'd1);
        step(3'b000, 6'd0, 6'd0, 3'b000);
        check("s1_memread_c4", 32'(MemRead), 32'd0);
        step(3'b000, 6'd0, 6'd0, 3'b000);
        check("s1_done_c5", 32'(Done), 32'b001);
        step(3'b000, 6'd0, 6'd0, 3'b000);
        check("s1_released_c6", 32'({Gnt, Done}), 32'd0);

        // Req=111 held from reset: round-robin 0,1,2,0
        do_reset();
        ng = 0; nd = 0;
        for (int i = 0; i < 4; i++) begin g_seq[i] = 3'b000; d_seq[i] = 3'b000; end
        for (int c = 0; c < 40 && nd < 4; c++) begin
            step(3'b111, 6'b000000, 6'($urandom_range(0, 63)), 3'b000);
            if (BusValid && ng < 4) begin g_seq[ng] = Gnt; ng++; end
            if (Done != 3'b000 && nd < 4) begin d_seq[nd] = Done; nd++; end
        end
        check("s2_grant0", 32'(g_seq[0]), 32'b001);
        check("s2_grant1", 32'(g_seq[1]), 32'b010);
        check("s2_grant2", 32'(g_seq[2]), 32'b100);
        check("s2_grant3", 32'(g_seq[3]), 32'b001);
        check("s2_done0", 32'(d_seq[0]), 32'b001);
        check("s2_done1", 32'(d_seq[1]), 32'b010);
        check("s2_done2", 32'(d_seq[2]), 32'b100);
        check("s2_done3", 32'(d_seq[3]), 32'b001);
        drain();

        // core 1 BusRdX, core 2 owns the line: FLUSH path
        step(3'b010, 6'b000100, 6'b001100, 3'b000);
        step(3'b000, 6'd0, 6'd0, 3'b000);
        step(3'b000, 6'd0, 6'd0, 3'b100);
        check("s3_memwrite", 32'(MemWrite), 32'd1);
        check("s3_abortmem", 32'(AbortMem), 32'd1);
        check("s3_no_memread", 32'(MemRead), 32'd0);
        step(3'b000, 6'd0, 6'd0, 3'b000);
        check("s3_done_c4", 32'(Done), 32'b010);
        check("s3_err", 32'(Err), 32'd0);
        drain();

        // core 2 BusUpgr, only its own hit bit set: direct completion
        step(3'b100, 6'b100000, 6'b010000, 3'b000);
        step(3'b000, 6'd0, 6'd0, 3'b000);
        step(3'b000, 6'd0, 6'd0, 3'b100);
        check("s4_done_c3", 32'(Done), 32'b100);
        check("s4_no_strobes", 32'({MemRead, MemWrite, AbortMem}), 32'd0);
        check("s4_err", 32'(Err), 32'd0);
        drain();

        // two foreign hits on a core-0 BusRd: FLUSH plus sticky Err
        step(3'b001, 6'b000000, 6'b000001, 3'b000);
        step(3'b000, 6'd0, 6'd0, 3'b000);
        step(3'b000, 6'd0, 6'd0, 3'b110);
        check("s5_err_set", 32'(Err), 32'd1);
        check("s5_flush", 32'(MemWrite), 32'd1);
        drain();
        step(3'b010, 6'b000000, 6'b000000, 3'b000);
        drain();
        check("s5_err_sticky", 32'(Err), 32'd1);

        // reset during MEM: abandon, then fresh grant from ptr 0
        step(3'b010, 6'b000000, 6'b000000, 3'b000);
        step(3'b000, 6'd0, 6'd0, 3'b000);
        step(3'b000, 6'd0, 6'd0, 3'b000);
        check("s6_in_mem", 32'(MemRead), 32'd1);
        do_reset();
        check("s6_err_cleared", 32'(Err), 32'd0);
        for (int c = 0; c < 4; c++) begin
            step(3'b000, 6'd0, 6'd0, 3'b000);
            check("s6_no_done", 32'(Done), 32'd0);
        end
        step(3'b111, 6'd0, 6'd0, 3'b000);
        check("s6_regrant_ptr0", 32'(Gnt), 32'b001);
        drain();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else
                step(($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7)),
                     rand_ops(), 6'($urandom_range(0, 63)), rand_hit());
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles, legal range 1..7.
REQ-002 SHALL have ports:
- Clock  in  1  sole clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  3  per-core bus request; bit i = core i.
- ReqOp  in  6  2 bits per core, core i at [2i+1:2i]: 00 BusRd, 01 BusRdX, 10 BusUpgr, 11 reserved.
- ReqAddr  in  6  2-bit line address per core, same packing as ReqOp.
- SnoopHit  in  3  core i holds the broadcast line in M.
- Gnt  out  3  one-hot grant, held for the whole transaction.
- BusValid  out  1  broadcast valid; high only in GRANT.
- BusOp  out  2  latched op of the granted core.
- BusAddr  out  2  latched address of the granted core.
- BusSrc  out  2  index of the granted core.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory writeback strobe.
- AbortMem  out  1  suppress the memory response; cache-to-cache supply.
- Done  out  3  one-cycle completion pulse to the requester.
- Err  out  1  sticky protocol-error flag.

Function
REQ-003 SHALL implement FSM states IDLE, GRANT, SNOOP, MEM, FLUSH and DONE.
REQ-004 In IDLE with any Req bit set, SHALL select a winner by round-robin starting at ptr, latch its op, addr and index, assert Gnt, and go to GRANT.
REQ-005 GRANT SHALL last exactly 1 cycle with BusValid=1, then go to SNOOP.
REQ-006 SNOOP SHALL last exactly 1 cycle and sample SnoopHit with the requester's own bit masked off.
REQ-007 From SNOOP:
- BusUpgr goes to DONE.
- Any masked hit with BusRd or BusRdX goes to FLUSH.
- Otherwise goes to MEM.
REQ-008 MEM SHALL last MEM_LAT cycles, counted by a 3-bit down-counter, with MemRead=1 on the first MEM cycle only, then go to DONE.
REQ-009 FLUSH SHALL last 1 cycle with MemWrite=1 and AbortMem=1, then go to DONE.
REQ-010 DONE SHALL last 1 cycle:
- Done[src]=1.
- Gnt is released at the end of the cycle.
- ptr is set to (src+1) mod 3.
- Next state is IDLE.
REQ-011 Latency from Req sampled to Done pulse SHALL be:
- BusUpgr: 3 cycles.
- FLUSH path: 4 cycles.
- MEM path: 3+MEM_LAT cycles.
REQ-012 A requester deasserting Req mid-transaction SHALL NOT abort the transaction; changes to ReqOp and ReqAddr after grant SHALL be ignored.
REQ-013 If more than one masked SnoopHit bit is set, the arbiter SHALL proceed to FLUSH and set Err.
REQ-014 Op 11 SHALL set Err and go from SNOOP directly to DONE with no memory strobe.
REQ-015 A request arriving while the bus is busy SHALL wait; the earliest re-grant is the cycle after DONE.
REQ-016 Any core holding Req continuously SHALL be granted within 2 other transactions (no starvation).
REQ-017 SHALL have no combinational path from any input to Gnt, Done, MemRead, MemWrite or AbortMem; all outputs are registered or decoded from state only.

Reset
REQ-018 On Reset the block SHALL immediately return to IDLE, including mid-transaction, and abandon any latched transaction without a Done pulse.
REQ-019 On Reset the following SHALL go to 0: ptr, Gnt, BusValid, BusOp, BusAddr, BusSrc, MemRead, MemWrite, AbortMem, Done and Err.
REQ-020 Err SHALL clear only on Reset.

Structure
REQ-021 The bus-op encodings, the FSM state encoding and MEM_LAT's default SHALL live in the shared package snoop_pkg, also used by the cores.
REQ-022 The round-robin winner select SHALL be the sub-module rr_pick3, which takes Req and ptr and returns a one-hot grant plus its index.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Req=001, op BusRd, addr 2, no hits: Gnt=001; MemRead pulse in cycle 3; Done=001 in cycle 5 with MEM_LAT=2; BusAddr=2.
- Req=111 held after reset: grants go 0, 1, 2, 0 in order; each grant gets one Done pulse.
- Core 1 BusRdX with SnoopHit=100 in SNOOP: FLUSH cycle shows MemWrite=1 and AbortMem=1; no MemRead; Done=010 after 4 cycles.
- Core 2 BusUpgr with SnoopHit=100 (own bit only): no FLUSH and no memory strobes; Done=100 after 3 cycles; Err=0.
- SnoopHit=110 on a core-0 BusRd: Err=1 and stays 1 through later transactions until Reset.
- Reset pulsed during MEM: all outputs 0 the same cycle; no Done pulse; next Req is granted normally from ptr=0.
